// File: rtl/xor_frame_pkg.sv
// Shared types and the fold step for the XOR frame checksum.
// The fold step optionally rotates the accumulator left by one bit
// (selected in xor_fold by the XOR_FRAME_ROTATE_EN macro).
package xor_frame_pkg;

  // ACC: accepting words of the current frame; HOLD: result presented.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Widest word the fold helper handles; callers zero-extend into this.
  localparam int unsigned FOLD_MAX_W = 64;

  // One fold step on the low `width` bits: (rotate ? rotl1(acc) : acc) ^ data.
  function automatic logic [FOLD_MAX_W-1:0] fold(
    input logic [FOLD_MAX_W-1:0] acc,
    input logic [FOLD_MAX_W-1:0] data,
    input int unsigned           width,
    input logic                  rotate
  );
    logic [FOLD_MAX_W-1:0] rot;
    rot = acc;
    if (rotate) begin
      rot    = '0;
      rot[0] = acc[6'(width - 1)];
      for (int i = 1; i < FOLD_MAX_W; i++) begin
        if (i < int'(width)) rot[i] = acc[i-1];
      end
    end
    return rot ^ data;
  endfunction

endpackage

// File: rtl/xor_fold.sv
// Combinational single fold step for the frame checksum.
// Macro XOR_FRAME_ROTATE_EN: when defined, the accumulator is rotated left
// by one before XOR, making the checksum order-sensitive.
module xor_fold
  import xor_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sum_o
);

`ifdef XOR_FRAME_ROTATE_EN
  localparam logic ROTATE = 1'b1;
`else
  localparam logic ROTATE = 1'b0;
`endif

  localparam int unsigned W_U = WIDTH;

  logic [FOLD_MAX_W-1:0] res;

  // Fold in the wide helper domain, then keep the low WIDTH bits.
  assign res   = fold(FOLD_MAX_W'(acc_i), FOLD_MAX_W'(data_i), W_U, ROTATE);
  assign sum_o = res[WIDTH-1:0];

  // Upper bits are always zero; tie them off explicitly.
  generate
    if (WIDTH < FOLD_MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^res[FOLD_MAX_W-1:WIDTH];
    end
  endgenerate

endmodule

// File: rtl/xor_frame_checksum.sv
// Streaming XOR frame checksum: folds a frame of WIDTH-bit words into one
// checksum, parity bit, saturating word count and overflow flag.
// Macro XOR_FRAME_ROTATE_EN selects the rotate-XOR fold (see xor_fold).
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. valid, once raised, is held with stable payload until that edge;
// ready may be asserted independently of valid. Here in_ready and out_valid
// are decoded from state alone, so there is no combinational path from
// in_valid/out_ready to the opposite side.
module xor_frame_checksum
  import xor_frame_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int MAX_LEN = 16,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow,
  output state_e           dbg_state
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    ocount_q, ocount_d;
  logic             oovf_q, oovf_d;

  logic [WIDTH-1:0] fold_res;
  logic             at_max;

  xor_fold #(.WIDTH(WIDTH)) u_fold (
    .acc_i  (acc_q),
    .data_i (in_data),
    .sum_o  (fold_res)
  );

  assign at_max = (count_q == MAX_CNT);

  // Next-state: accumulate beats in ACC, latch result on last, release in HOLD.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    sum_d    = sum_q;
    ocount_d = ocount_q;
    oovf_d   = oovf_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d   = fold_res;
          count_d = at_max ? MAX_CNT : count_q + CW'(1);
          ovf_d   = ovf_q | at_max;
          if (in_last) begin
            sum_d    = fold_res;
            ocount_d = count_d;
            oovf_d   = ovf_d;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State and datapath registers; synchronous reset drops any frame or result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACC;
      acc_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      sum_q    <= '0;
      ocount_q <= '0;
      oovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      sum_q    <= sum_d;
      ocount_q <= ocount_d;
      oovf_q   <= oovf_d;
    end
  end

  assign in_ready     = (state_q == ACC);
  assign out_valid    = (state_q == HOLD);
  assign out_sum      = sum_q;
  assign out_parity   = ^sum_q;
  assign out_count    = ocount_q;
  assign out_overflow = oovf_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Directed bench for xor_frame_checksum (WIDTH=8, MAX_LEN=4).
// Expected sums depend on XOR_FRAME_ROTATE_EN and are hand-computed for both.
module tb_xor_frame_checksum;
  import xor_frame_pkg::*;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;
  localparam int CW      = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_parity;
  logic [CW-1:0]    out_count;
  logic             out_overflow;
  state_e           dbg_state;

  int compared   = 0;
  int mismatched = 0;

  xor_frame_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_parity   (out_parity),
    .out_count    (out_count),
    .out_overflow (out_overflow),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat; waits (bounded) for in_ready, sampled at negedge.
  task automatic send(input logic [7:0] d, input logic l);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready_wait", 32'(guard < 50), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'hXX;
  endtask

  // Check the presented result, handshake it, check release.
  task automatic take(input string tag, input logic [7:0] s, input logic p,
                      input logic [CW-1:0] c, input logic o);
    @(negedge clk);
    chk({tag, "_valid"},  32'(out_valid), 32'd1);
    chk({tag, "_sum"},    32'(out_sum), 32'(s));
    chk({tag, "_parity"}, 32'(out_parity), 32'(p));
    chk({tag, "_count"},  32'(out_count), 32'(c));
    chk({tag, "_ovf"},    32'(out_overflow), 32'(o));
    chk({tag, "_inrdy"},  32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_released"}, 32'(out_valid), 32'd0);
    chk({tag, "_inrdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] e_basic, e_ovf, e_fullx, e_ab, e_ba, e_mid;

`ifdef XOR_FRAME_ROTATE_EN
    e_basic = 8'h2F; e_ovf = 8'h04; e_fullx = 8'h00; e_ab = 8'h00; e_ba = 8'h82;
    e_mid = 8'h44;
`else
    e_basic = 8'h29; e_ovf = 8'h07; e_fullx = 8'h0F; e_ab = 8'h81; e_ba = 8'h81;
    e_mid = 8'h44;
`endif

    // Reset for 2 cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    chk("rst_outvalid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ovf", 32'(out_overflow), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ACC));

    // Basic frame
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h0F, 1'b1);
    take("basic", e_basic, 1'b1, 3'd3, 1'b0);

    // Backpressure: hold 5 cycles with out_ready low
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h0F, 1'b1);
    in_valid = 1'b1;  // source waiting with a word; must not be accepted
    in_data  = 8'hFF;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_inrdy", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(out_sum), 32'(e_basic));
      chk("bp_count", 32'(out_count), 32'd3);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    take("bp", e_basic, 1'b1, 3'd3, 1'b0);
    send(8'h5A, 1'b1);
    take("after_bp", 8'h5A, 1'b0, 3'd1, 1'b0);

    // Exactly MAX_LEN words: no overflow
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h04, 1'b0);
    send(8'h08, 1'b1);
    take("full", e_fullx, ^e_fullx, 3'd4, 1'b0);

    // Overflow: 6 words with MAX_LEN=4
    for (int i = 1; i <= 6; i++) send(8'(i), 1'(i == 6));
    take("ovf", e_ovf, 1'b1, 3'd4, 1'b1);
    send(8'h3C, 1'b1);
    take("post_ovf", 8'h3C, 1'b0, 3'd1, 1'b0);

    // Single word
    send(8'hA5, 1'b1);
    take("single", 8'hA5, 1'b0, 3'd1, 1'b0);

    // Reset mid-frame after 2 words
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_inrdy", 32'(in_ready), 32'd1);
    chk("midrst_outvalid", 32'(out_valid), 32'd0);
    send(8'h44, 1'b1);
    take("midrst", e_mid, 1'b0, 3'd1, 1'b0);

    // Reset while a result is pending
    send(8'h55, 1'b1);
    @(negedge clk);
    chk("holdrst_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("holdrst_valid", 32'(out_valid), 32'd0);
    chk("holdrst_sum", 32'(out_sum), 32'd0);
    chk("holdrst_inrdy", 32'(in_ready), 32'd1);

    // Order sensitivity
    send(8'h80, 1'b0);
    send(8'h01, 1'b1);
    take("order_ab", e_ab, ^e_ab, 3'd2, 1'b0);
    send(8'h01, 1'b0);
    send(8'h80, 1'b1);
    take("order_ba", e_ba, ^e_ba, 3'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/xor_frame_checksum.md
Name: xor_frame_checksum

Overview:
- Streaming, parametrised successor to the team's 1-bit two-input XOR gate.
- Folds a frame of WIDTH-bit words into one WIDTH-bit XOR checksum and one parity bit.
- Input and output both use valid/ready handshakes.
- Sits between a word source and a checker or packet framer; one frame in flight at a time.

Parameters:
- WIDTH, 8: data word and checksum width in bits, ≥1.
- MAX_LEN, 16: words per frame before overflow is flagged, ≥1.
- CW, $clog2(MAX_LEN+1): count width. Derived; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  input word.
- in_last  in  1  final word of the frame; qualified by in_valid.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  XOR of all accepted words in the frame.
- out_parity  out  1  reduction-XOR of out_sum.
- out_count  out  CW  accepted words, saturating at MAX_LEN.
- out_overflow  out  1  frame had more than MAX_LEN words.

Behaviour:
- Interface is fixed: one clock `clk`; `rst` is synchronous, active-high.
- Reset (clk edge with rst=1):
  - state=ACC; acc, count, overflow, out_sum, out_count = 0.
  - out_valid=0, out_overflow=0, in_ready=1.
  - rst overrides everything, including a frame or result in progress. The partial frame is discarded and any pending result is dropped.
- States: ACC (accepting words), HOLD (result presented).
- in_ready = (state==ACC). out_valid = (state==HOLD). Both are purely state-decoded.
- ACC, beat accepted (in_valid & in_ready):
  - acc <= acc ^ in_data.
  - count <= (count==MAX_LEN) ? MAX_LEN : count+1.
  - If count==MAX_LEN before this beat, overflow <= 1 (sticky for the frame). The beat is still XORed in.
- ACC, accepted beat with in_last=1:
  - out_sum <= acc ^ in_data; out_count and out_overflow get the post-beat values.
  - state <= HOLD.
  - Latency: result valid one cycle after the last beat.
- A single-word frame (first beat has in_last=1) is legal. Result is out_sum=in_data, out_count=1.
- HOLD:
  - in_ready=0.
  - out_sum, out_parity, out_count, out_overflow are stable while out_valid=1.
  - On out_valid & out_ready: acc, count, overflow <= 0; state <= ACC.
  - in_ready rises the cycle after the output handshake. There is no same-cycle bypass.
- out_parity = ^out_sum, combinational from the register.
- in_data and in_last are ignored when in_valid=0. in_valid in HOLD is simply not accepted; the source must hold it.
- No X propagation: all registers reset.

Optional Feature:
- Macro: XOR_FRAME_ROTATE_EN.
- Defined: each accepted beat computes acc <= rotl1(acc) ^ in_data (rotate left by 1 within WIDTH). The final out_sum uses the same fold. This makes the checksum order-sensitive.
- Undefined: plain XOR as above, order-insensitive.
- Parity is always the reduction-XOR of out_sum.

Decomposition:
- Package xor_frame_pkg:
  - state typedef {ACC, HOLD}.
  - Function fold(acc, data) implementing the XOR / rotate-XOR step.
- Sub-module xor_fold: combinational, WIDTH-parametrised, one fold step. Instantiated once; the macro selects the rotate path inside it.
- Top-level holds the FSM, counters and output registers.

Test Plan:
- Reset sequence: rst=1 for 2 cycles → in_ready=1, out_valid=0, out_sum=0x00, out_count=0, out_overflow=0.
- Frame 0x12, 0x34, 0x0F (last), out_ready=1 → out_valid=1 one cycle after last; out_sum=0x29, out_parity=1, out_count=3, overflow=0; in_ready returns the next cycle.
- Backpressure: same frame with out_ready=0 for 5 cycles → out_valid held, outputs stable, in_ready=0 throughout; handshake on cycle 6 → next frame accepted.
- Overflow with MAX_LEN=4: 6 words 0x01..0x06 (last on 0x06) → out_sum=0x07, out_count=4, out_overflow=1; the following frame reports overflow=0.
- Single word 0xA5 with last → out_sum=0xA5, out_parity=0, out_count=1. Reset asserted mid-frame after 2 words → next frame's result excludes them.
- With XOR_FRAME_ROTATE_EN, WIDTH=8: 0x80 then 0x01 (last) → out_sum=0x00. Reversed order 0x01, 0x80 → out_sum=0x82. Without the macro, both orders give 0x81.
